// File: rtl/ccsds_turbo_dec_depunct.sv
// Depuncturer: rebuilds one soft word per trellis step from the serial LLR stream; erasures are 0.
// Latency 1 cycle from the last sample of a step; no backpressure, iclkena freezes all state.
module ccsds_turbo_dec_depunct #(
  parameter int pLLR_W = 5
) (
  input  logic                           iclk,
  input  logic                           ireset,
  input  logic                           iclkena,
  input  logic [1:0]                     icode,
  input  logic                           isop,
  input  logic                           ival,
  input  logic                           ieop,
  input  logic [pLLR_W-1:0]              idat,
  output logic                           osop,
  output logic                           oval,
  output logic                           oeop,
  output logic [1:0][3:0][pLLR_W-1:0]    odat,
  output logic                           oerr
);

  typedef logic [1:0][3:0][pLLR_W-1:0] word_t;

  logic [1:0] code;
  logic [2:0] p;
  logic       tog;
  word_t      acc;
  logic       acc_sop;

  logic [1:0] code_eff;
  logic [2:0] p_eff;
  logic       tog_eff;
  logic [2:0] last_p;
  logic       fc;
  logic [1:0] fk;
  word_t      acc_nxt;
  logic       sop_nxt;
  logic       wrap;

  // isop restarts the step in the same cycle it arrives, discarding any partial word
  always_comb begin
    code_eff = isop ? icode : code;
    p_eff    = isop ? 3'd0 : p;
    tog_eff  = isop ? 1'b0 : tog;
    last_p   = 3'd1;
    fc       = 1'b0;
    fk       = 2'd0;
    case (code_eff)
      2'd0: begin
        last_p = 3'd1;
        if (p_eff == 3'd1) begin fc = tog_eff; fk = 2'd1; end
      end
      2'd1: begin
        last_p = 3'd2;
        case (p_eff)
          3'd1:    begin fc = 1'b0; fk = 2'd1; end
          3'd2:    begin fc = 1'b1; fk = 2'd1; end
          default: begin fc = 1'b0; fk = 2'd0; end
        endcase
      end
      2'd2: begin
        last_p = 3'd3;
        case (p_eff)
          3'd1:    begin fc = 1'b0; fk = 2'd2; end
          3'd2:    begin fc = 1'b0; fk = 2'd3; end
          3'd3:    begin fc = 1'b1; fk = 2'd1; end
          default: begin fc = 1'b0; fk = 2'd0; end
        endcase
      end
      default: begin
        last_p = 3'd5;
        case (p_eff)
          3'd1:    begin fc = 1'b0; fk = 2'd1; end
          3'd2:    begin fc = 1'b0; fk = 2'd2; end
          3'd3:    begin fc = 1'b0; fk = 2'd3; end
          3'd4:    begin fc = 1'b1; fk = 2'd1; end
          3'd5:    begin fc = 1'b1; fk = 2'd3; end
          default: begin fc = 1'b0; fk = 2'd0; end
        endcase
      end
    endcase
    acc_nxt         = (p_eff == 3'd0) ? '0 : acc;
    acc_nxt[fc][fk] = idat;
    sop_nxt         = (p_eff == 3'd0) ? isop : acc_sop;
    wrap            = (p_eff == last_p) || ieop;
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      osop    <= 1'b0;
      oval    <= 1'b0;
      oeop    <= 1'b0;
      oerr    <= 1'b0;
      odat    <= '0;
      code    <= 2'd0;
      p       <= 3'd0;
      tog     <= 1'b0;
      acc     <= '0;
      acc_sop <= 1'b0;
    end else if (iclkena) begin
      oval <= 1'b0;
      osop <= 1'b0;
      oeop <= 1'b0;
      oerr <= 1'b0;
      if (ival) begin
        if (isop) code <= icode;
        acc     <= acc_nxt;
        acc_sop <= sop_nxt;
        if (wrap) begin
          oval <= 1'b1;
          odat <= acc_nxt;
          osop <= sop_nxt;
          oeop <= ieop;
          oerr <= ieop && (p_eff != last_p);
          p    <= 3'd0;
          // only a completed rate-1/2 step alternates the parity source
          tog  <= (code_eff == 2'd0 && !ieop) ? ~tog_eff : 1'b0;
        end else begin
          p   <= 3'(p_eff + 3'd1);
          tog <= tog_eff;
        end
      end
    end
  end

endmodule

// File: doc/ccsds_turbo_dec_depunct.md
Name: ccsds_turbo_dec_depunct

Overview:
- Receive-side inverse of the turbo encoder puncture/serializer.
- Accepts a serial stream of soft bits (signed LLRs), one per valid cycle, in the transmit order defined for each code rate.
- Reassembles one soft word per trellis step for the turbo decoder input buffer.
- Inserts erasures (LLR = 0) at every punctured or non-transmitted position.

Parameters:
- pLLR_W, 5, signed LLR width in bits (two's complement).

Ports:
- iclk     input   1              clock
- ireset   input   1              synchronous active-high reset
- iclkena  input   1              clock enable; when low, all state holds
- icode    input   2              code rate: 0 = 1/2, 1 = 1/3, 2 = 1/4, 3 = 1/6; sampled only on (ival & isop)
- isop     input   1              first soft bit of a frame
- ival     input   1              soft bit valid
- ieop     input   1              last soft bit of a frame
- idat     input   pLLR_W         soft bit
- osop     output  1              first word of a frame
- oval     output  1              word valid
- oeop     output  1              last word of a frame
- odat     output  2 x 4 x pLLR_W word as [component c][stream k]: c0 = natural encoder, c1 = interleaved encoder; k0 = systematic, k1..k3 = parities
- oerr     output  1              frame ended on an incomplete word

Behaviour:
- Reset is synchronous, active-high, and effective regardless of iclkena. It clears osop, oval, oeop, oerr, odat (all zeros), the position counter, the parity toggle, and the latched code (defaults to 0).
- All other updates occur only when iclkena = 1.
- Group size N per step: 1/2 = 2, 1/3 = 3, 1/4 = 4, 1/6 = 6.
- Serial position p = 0..N-1 maps to odat fields as follows:
  - 1/2: p0 -> [0][0]; p1 -> [0][1] on even steps, [1][1] on odd steps. The step index counts from 0 at isop.
  - 1/3: p0 -> [0][0], p1 -> [0][1], p2 -> [1][1].
  - 1/4: p0 -> [0][0], p1 -> [0][2], p2 -> [0][3], p3 -> [1][1].
  - 1/6: p0 -> [0][0], p1 -> [0][1], p2 -> [0][2], p3 -> [0][3], p4 -> [1][1], p5 -> [1][3].
- [1][0] is always 0: the interleaved systematic stream is never transmitted.
- Any field not written within a step is 0.
- Accumulation:
  - On each ival cycle, write idat into the field selected by (code, p, toggle) of an internal assembly register.
  - A new step starts with the assembly register cleared before the p0 write.
  - Cycles with ival = 0 are gaps: p, toggle and the assembly register all hold. Unlimited gaps are allowed.
- Word emission:
  - When the sample at p = N-1 is accepted, the next cycle presents the completed word on odat with oval = 1 for exactly one enabled cycle. Latency is 1 cycle from the last sample.
  - p then wraps to 0, and for 1/2 the toggle inverts.
- osop = 1 on the first word emitted after an (isop & ival) sample. oeop = 1 on the word containing the (ieop & ival) sample.
- When oval = 0, odat holds its last value; osop, oeop and oerr are 0.
- isop handling:
  - (ival & isop) forces p = 0 and toggle = 0 (even step), and latches icode.
  - Any partially assembled word is discarded silently.
  - isop arriving while p != 0 does not raise oerr.
- ieop handling:
  - (ival & ieop) at p = N-1: normal completion, oeop = 1, oerr = 0.
  - (ival & ieop) at p < N-1: the word is flushed the next cycle with oval = 1, oeop = 1, oerr = 1. Missing fields are 0.
  - In either case p and toggle return to 0.
- isop and ieop on the same sample: the frame is one sample long. The word is flushed with osop = oeop = 1. oerr = 1 unless N = 1 (never the case), so oerr = 1.
- Samples after ieop and before the next isop are still assembled using the latched code. osop stays 0 until an isop is seen.
- icode changes without isop are ignored.
- Reset mid-frame: the partial word is lost, and the next frame must start with isop.

Test Plan:
- Rate 1/2, frame of 4 steps, samples 1,2,3,4,5,6,7,8, isop on 1, ieop on 8, no gaps -> 4 words, each 1 cycle after its p1 sample:
  - [0][0] = 1,3,5,7.
  - [0][1] = 2,0,6,0.
  - [1][1] = 0,4,0,8.
  - osop on word0, oeop on word3, oerr = 0.
- Rate 1/6, one step, samples -1,2,-3,4,-5,6 with a 3-cycle ival gap after the 2nd sample:
  - Single word [0][0..3] = -1,2,-3,4; [1][1] = -5; [1][3] = 6; others 0.
  - oval 1 cycle after sample 6.
- Rate 1/4, ieop on p2 of step 2 (samples 9,10,11) -> flushed word [0][0] = 9, [0][2] = 10, [0][3] = 11, [1][1] = 0, with oeop = 1 and oerr = 1.
- Rate 1/3, isop reasserted at p1 of step 5 with icode = 3 -> the partial step-5 word is never emitted, the next words are decoded as rate 1/6, and osop = 1 on the first of them.
- iclkena low for 5 cycles mid-word, with ival toggling during those cycles -> no state change, and output identical to the same run without the stall.
- ireset asserted for 1 cycle at p2 of a rate 1/4 frame -> all outputs 0 the next cycle, and a fresh frame after reset decodes correctly at default code 0 unless isop latches a new one.
